// File: rtl/impact_sound_pkg.sv
// Shared definitions for the impact sound generator and the collision stage:
// state encoding, impact-code bit positions and the envelope start level.
package impact_sound_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RING = 1'b1
  } state_e;

  localparam int IMP_STROBE = 0;
  localparam int IMP_S_LSB  = 1;
  localparam int IMP_S_MSB  = 2;

  // Starting envelope for strength s: 4*s+3, i.e. 3/7/11/15.
  function automatic logic [3:0] env_init(input logic [1:0] s);
    return {s, 2'b11};
  endfunction

endpackage

// File: rtl/impact_tone.sv
// Square-wave tone generator: a half-period down-counter and a tone flip-flop.
// A load restarts the wave high; dropping run silences it.
module impact_tone
  import impact_sound_pkg::*;
#(
  parameter int HALF_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [HALF_W-1:0] half,
  input  logic              run,
  output logic              tone
);

  logic [HALF_W-1:0] half_q, half_d;
  logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
  logic              tone_q, tone_d;

  always_comb begin
    half_d     = half_q;
    half_cnt_d = half_cnt_q;
    tone_d     = tone_q;
    if (load) begin
      half_d     = half;
      half_cnt_d = half - HALF_W'(1);
      tone_d     = 1'b1;
    end else if (run) begin
      if (half_cnt_q == '0) begin
        tone_d     = ~tone_q;
        half_cnt_d = half_q - HALF_W'(1);
      end else begin
        half_cnt_d = half_cnt_q - HALF_W'(1);
      end
    end else begin
      half_cnt_d = '0;
      tone_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      half_q     <= '0;
      half_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else begin
      half_q     <= half_d;
      half_cnt_q <= half_cnt_d;
      tone_q     <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/impact_sound.sv
// Turns collision strikes into a decaying square-wave clack on a 1-bit PWM pin.
// Envelope, IDLE/RING state and PWM live here; the tone comes from impact_tone.
module impact_sound
  import impact_sound_pkg::*;
#(
  parameter int HALF0  = 200,
  parameter int HALF_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [2:0] impact,
  output logic       audio,
  output logic       busy,
  output logic [3:0] level
);

  localparam logic [HALF_W-1:0] HALF_S0 = HALF_W'(HALF0);
  localparam logic [HALF_W-1:0] HALF_S1 = HALF_W'(HALF0 >> 1);
  localparam logic [HALF_W-1:0] HALF_S2 = HALF_W'(HALF0 >> 2);
  localparam logic [HALF_W-1:0] HALF_S3 = HALF_W'(HALF0 >> 3);

  state_e            state_q, state_d;
  logic [3:0]        level_q, level_d;
  logic [3:0]        pwm_cnt_q, pwm_cnt_d;
  logic              audio_q, audio_d;
  logic              strike_s;
  logic [1:0]        str_s;
  logic [3:0]        init_s;
  logic [HALF_W-1:0] half_sel_s;
  logic              run_s;
  logic              tone_s;

  assign strike_s = impact[IMP_STROBE];
  assign str_s    = impact[IMP_S_MSB:IMP_S_LSB];
  assign init_s   = env_init(str_s);

  always_comb begin
    case (str_s)
      2'd0:    half_sel_s = HALF_S0;
      2'd1:    half_sel_s = HALF_S1;
      2'd2:    half_sel_s = HALF_S2;
      2'd3:    half_sel_s = HALF_S3;
      default: half_sel_s = HALF_S0;
    endcase
  end

  // A strike beats a same-cycle tick; a retrigger never lowers the envelope.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (strike_s) begin
      state_d = ST_RING;
      if ((state_q == ST_RING) && (level_q > init_s)) begin
        level_d = level_q;
      end else begin
        level_d = init_s;
      end
    end else if (tick && (state_q == ST_RING)) begin
      if (level_q <= 4'd1) begin
        level_d = 4'd0;
        state_d = ST_IDLE;
      end else begin
        level_d = level_q - 4'd1;
      end
    end else begin
      level_d = level_q;
    end
  end

  assign run_s     = (state_d == ST_RING);
  assign pwm_cnt_d = pwm_cnt_q + 4'd1;
  assign audio_d   = tone_s & (pwm_cnt_q < level_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      level_q   <= 4'd0;
      pwm_cnt_q <= 4'd0;
      audio_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      pwm_cnt_q <= pwm_cnt_d;
      audio_q   <= audio_d;
    end
  end

  impact_tone #(
    .HALF_W (HALF_W)
  ) u_tone (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (strike_s),
    .half  (half_sel_s),
    .run   (run_s),
    .tone  (tone_s)
  );

  assign audio = audio_q;
  assign busy  = (state_q == ST_RING);
  assign level = level_q;

endmodule

// File: tb/tb_impact_sound.sv
// Directed bench for impact_sound: expectations are queued when stimulus is
// applied and popped against the DUT after the clock edge.
module tb_impact_sound;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [2:0] impact;
  logic       audio;
  logic       busy;
  logic [3:0] level;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   hi_cnt;

  impact_sound #(
    .HALF0  (200),
    .HALF_W (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (tick),
    .impact (impact),
    .audio  (audio),
    .busy   (busy),
    .level  (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic exp_push(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.exp = val;
    sb.push_back(e);
  endtask

  task automatic sb_check(input logic [7:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %0d with no expected entry", obs);
    end else begin
      e = sb.pop_front();
      n_tests++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    tick   = 1'b1;
    impact = 3'b111;

    // Reset held with strike and tick asserted.
    for (int i = 0; i < 2; i++) begin
      exp_push("rst_audio", 8'd0);
      exp_push("rst_busy", 8'd0);
      exp_push("rst_level", 8'd0);
      exp_push("rst_pwm", 8'd0);
      step();
      sb_check(8'(audio));
      sb_check(8'(busy));
      sb_check(8'(level));
      sb_check(8'(dut.pwm_cnt_q));
    end
    rst_n  = 1'b1;
    tick   = 1'b0;
    impact = 3'b000;
    exp_push("pwm_after_rst", 8'd1);
    step();
    sb_check(8'(dut.pwm_cnt_q));

    // Strong strike: level 15, half period 25.
    impact = 3'b111;
    exp_push("s3_level", 8'd15);
    exp_push("s3_busy", 8'd1);
    exp_push("s3_tone", 8'd1);
    step();
    impact = 3'b000;
    sb_check(8'(level));
    sb_check(8'(busy));
    sb_check(8'(dut.tone_s));
    exp_push("s3_tone_e24", 8'd1);
    steps(24);
    sb_check(8'(dut.tone_s));
    exp_push("s3_tone_e25", 8'd0);
    step();
    sb_check(8'(dut.tone_s));
    exp_push("s3_audio_low_phase", 8'd0);
    hi_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      hi_cnt += int'(audio);
    end
    sb_check(8'(hi_cnt));
    exp_push("s3_tone_e50", 8'd1);
    steps(9);
    sb_check(8'(dut.tone_s));
    exp_push("s3_duty_15_of_16", 8'd15);
    hi_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      hi_cnt += int'(audio);
    end
    sb_check(8'(hi_cnt));

    // Strength bits without strobe are ignored while ringing.
    impact = 3'b110;
    exp_push("inv_ring_level", 8'd15);
    exp_push("inv_ring_busy", 8'd1);
    step();
    impact = 3'b000;
    sb_check(8'(level));
    sb_check(8'(busy));

    // Mid-ring reset pulse.
    rst_n = 1'b0;
    exp_push("midrst_audio", 8'd0);
    exp_push("midrst_busy", 8'd0);
    exp_push("midrst_level", 8'd0);
    exp_push("midrst_tone", 8'd0);
    step();
    rst_n = 1'b1;
    sb_check(8'(audio));
    sb_check(8'(busy));
    sb_check(8'(level));
    sb_check(8'(dut.tone_s));
    exp_push("post_rst_busy", 8'd0);
    exp_push("post_rst_audio", 8'd0);
    steps(3);
    sb_check(8'(busy));
    sb_check(8'(audio));
    impact = 3'b110;
    exp_push("inv_idle_busy", 8'd0);
    exp_push("inv_idle_level", 8'd0);
    step();
    impact = 3'b000;
    sb_check(8'(busy));
    sb_check(8'(level));

    // Weak strike decays to silence over three ticks.
    impact = 3'b001;
    exp_push("s0_level", 8'd3);
    exp_push("s0_busy", 8'd1);
    step();
    impact = 3'b000;
    sb_check(8'(level));
    sb_check(8'(busy));
    steps(2);
    for (int i = 2; i >= 1; i--) begin
      tick = 1'b1;
      exp_push("decay_level", 8'(i));
      step();
      tick = 1'b0;
      sb_check(8'(level));
    end
    tick = 1'b1;
    exp_push("decay_last_level", 8'd0);
    exp_push("decay_last_busy", 8'd0);
    exp_push("decay_last_tone", 8'd0);
    step();
    tick = 1'b0;
    sb_check(8'(level));
    sb_check(8'(busy));
    sb_check(8'(dut.tone_s));
    exp_push("silent_after_decay", 8'd0);
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      hi_cnt += int'(audio);
    end
    sb_check(8'(hi_cnt));

    // Retrigger: s=3 decayed to 5, then s=1 raises to 7, then s=0 keeps 7.
    impact = 3'b111;
    step();
    impact = 3'b000;
    for (int i = 0; i < 10; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
    exp_push("retrig_pre_level", 8'd5);
    sb_check(8'(level));
    impact = 3'b011;
    exp_push("retrig_s1_level", 8'd7);
    exp_push("retrig_s1_busy", 8'd1);
    step();
    impact = 3'b000;
    sb_check(8'(level));
    sb_check(8'(busy));
    exp_push("retrig_s1_tone_e99", 8'd1);
    steps(99);
    sb_check(8'(dut.tone_s));
    exp_push("retrig_s1_tone_e100", 8'd0);
    step();
    sb_check(8'(dut.tone_s));
    impact = 3'b001;
    exp_push("retrig_s0_level", 8'd7);
    exp_push("retrig_s0_tone", 8'd1);
    step();
    impact = 3'b000;
    sb_check(8'(level));
    sb_check(8'(dut.tone_s));
    exp_push("retrig_s0_tone_e199", 8'd1);
    steps(199);
    sb_check(8'(dut.tone_s));
    exp_push("retrig_s0_tone_e200", 8'd0);
    step();
    sb_check(8'(dut.tone_s));
    for (int i = 0; i < 7; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
    exp_push("retrig_end_level", 8'd0);
    exp_push("retrig_end_busy", 8'd0);
    sb_check(8'(level));
    sb_check(8'(busy));

    // Strike and tick together from IDLE: strike wins, no decay.
    impact = 3'b101;
    tick   = 1'b1;
    exp_push("simul_level", 8'd11);
    exp_push("simul_busy", 8'd1);
    step();
    impact = 3'b000;
    sb_check(8'(level));
    sb_check(8'(busy));
    exp_push("simul_next_tick", 8'd10);
    step();
    tick = 1'b0;
    sb_check(8'(level));

    if (sb.size() != 0) begin
      n_fail++;
      $error("FAIL sb_leftover: observed %0d entries expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
